// File: rtl/demux_stream_scheduler_if.sv
// Handshake bundle between the word source, the scheduler and the DEMUX channels.
// Drop_Out exists only when DEMUX_SCHED_TIMEOUT_EN is defined.
interface demux_stream_scheduler_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int SEL_WIDTH    = 2
);
    logic                    Enable_In;
    logic [DATA_WIDTH-1:0]   Data_In;
    logic                    Valid_In;
    logic                    Ready_Out;
    logic [NUM_CHANNELS-1:0] Channel_Ready_In;
    logic [DATA_WIDTH-1:0]   Data_Out;
    logic [SEL_WIDTH-1:0]    Select_Out;
    logic [NUM_CHANNELS-1:0] Channel_Valid_Out;
    logic                    Busy_Out;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    logic                    Drop_Out;
`endif

    modport master (
        output Enable_In, Data_In, Valid_In, Channel_Ready_In,
        input  Ready_Out, Data_Out, Select_Out, Channel_Valid_Out,
               Busy_Out
`ifdef DEMUX_SCHED_TIMEOUT_EN
        , input Drop_Out
`endif
    );

    modport slave (
        input  Enable_In, Data_In, Valid_In, Channel_Ready_In,
        output Ready_Out, Data_Out, Select_Out, Channel_Valid_Out,
               Busy_Out
`ifdef DEMUX_SCHED_TIMEOUT_EN
        , output Drop_Out
`endif
    );
endinterface

// File: rtl/demux_stream_scheduler.sv
// Round-robin scheduler feeding a 1:N DEMUX; skips busy channels, one word in flight.
// Optional arbitration timeout with word drop: define DEMUX_SCHED_TIMEOUT_EN.
module demux_stream_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CHANNELS   = 4,
    parameter int SEL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                     Clock_In,
    input logic                     Reset_In,
    demux_stream_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARBITRATE = 2'd1,
        DELIVER   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic [SEL_WIDTH-1:0]    ptr_q;
    logic [NUM_CHANNELS-1:0] cv_q;

    logic                    accept;
    logic                    found;
    logic [SEL_WIDTH-1:0]    pick;
    logic [SEL_WIDTH-1:0]    idx;
    logic                    sel_ready;
    logic                    expire;

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q;
    logic          drop_q;
`endif

    assign accept    = (state == IDLE) && bus.Enable_In && bus.Valid_In;
    assign sel_ready = bus.Channel_Ready_In[sel_q];

    // First ready channel at or after the pointer, wrapping modulo N
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx = ptr_q + SEL_WIDTH'(i);
            if (!found && bus.Channel_Ready_In[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

`ifdef DEMUX_SCHED_TIMEOUT_EN
    assign expire = !found && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = ARBITRATE;
            end
            ARBITRATE: begin
                if (found)       state_next = DELIVER;
                else if (expire) state_next = IDLE;
            end
            DELIVER: begin
                if (sel_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            data_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
            cv_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) data_q <= bus.Data_In;
                end
                ARBITRATE: begin
                    if (found) begin
                        sel_q <= pick;
                        cv_q  <= NUM_CHANNELS'(1) << pick;
                    end
                end
                DELIVER: begin
                    if (sel_ready) begin
                        cv_q  <= '0;
                        ptr_q <= sel_q + SEL_WIDTH'(1);
                    end
                end
                default: cv_q <= '0;
            endcase
        end
    end

`ifdef DEMUX_SCHED_TIMEOUT_EN
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= (state == ARBITRATE) && expire;
            if (accept)
                cnt_q <= '0;
            else if (state == ARBITRATE && !found && !expire)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.Drop_Out = drop_q;
`endif

    assign bus.Ready_Out         = (state == IDLE) && bus.Enable_In;
    assign bus.Busy_Out          = (state != IDLE);
    assign bus.Data_Out          = data_q;
    assign bus.Select_Out        = sel_q;
    assign bus.Channel_Valid_Out = cv_q;
endmodule

// File: tb/tb_demux_stream_scheduler.sv
// Directed checks of the round-robin DEMUX scheduler.
// Timeout drop is exercised only when DEMUX_SCHED_TIMEOUT_EN is defined.
module tb_demux_stream_scheduler;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    demux_stream_scheduler_if #(
        .DATA_WIDTH(8), .NUM_CHANNELS(4), .SEL_WIDTH(2)
    ) sif ();

    demux_stream_scheduler #(
        .DATA_WIDTH(8), .NUM_CHANNELS(4), .SEL_WIDTH(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .Clock_In(clk),
        .Reset_In(rst),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at first edge, select at second, complete at third
    task automatic send(input logic [7:0] d, input int ch);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        sif.Data_In  = d;
        sif.Valid_In = 1'b1;
        tick();
        sif.Valid_In = 1'b0;
        check("acc_busy", 32'(sif.Busy_Out), 32'd1);
        check("acc_rdy", 32'(sif.Ready_Out), 32'd0);
        check("acc_cv", 32'(sif.Channel_Valid_Out), 32'd0);
        tick();
        check("sel_cv", 32'(sif.Channel_Valid_Out), 32'(oh));
        check("sel_sel", 32'(sif.Select_Out), 32'(ch));
        check("sel_data", 32'(sif.Data_Out), 32'(d));
        tick();
        check("done_cv", 32'(sif.Channel_Valid_Out), 32'd0);
        check("done_rdy", 32'(sif.Ready_Out), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        sif.Enable_In        = 1'b1;
        sif.Data_In          = '0;
        sif.Valid_In         = 1'b0;
        sif.Channel_Ready_In = 4'b1111;
        #12;
        check("rst_cv", 32'(sif.Channel_Valid_Out), 32'd0);
        check("rst_busy", 32'(sif.Busy_Out), 32'd0);
        check("rst_data", 32'(sif.Data_Out), 32'd0);
        check("rst_sel", 32'(sif.Select_Out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_rdy", 32'(sif.Ready_Out), 32'd1);

        // All ready: strict rotation 0..3 twice
        for (int i = 0; i < 8; i++)
            send(8'(8'h10 + i), i % 4);

        // Channels 0 and 2 busy: 1, 3, wrap to 1
        sif.Channel_Ready_In = 4'b1010;
        send(8'h21, 1);
        send(8'h22, 3);
        send(8'h23, 1);

        // Ptr=2: pick 2, then ready[2] drops while 0 is ready
        sif.Channel_Ready_In = 4'b1111;
        sif.Data_In  = 8'hA5;
        sif.Valid_In = 1'b1;
        tick();
        sif.Valid_In = 1'b0;
        tick();
        check("hold_pick", 32'(sif.Channel_Valid_Out), 32'h4);
        sif.Channel_Ready_In = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_cv", 32'(sif.Channel_Valid_Out), 32'h4);
            check("hold_data", 32'(sif.Data_Out), 32'hA5);
        end
        sif.Channel_Ready_In = 4'b0101;
        tick();
        check("hold_done", 32'(sif.Channel_Valid_Out), 32'd0);
        check("hold_busy", 32'(sif.Busy_Out), 32'd0);

        // Enable low blocks acceptance
        sif.Channel_Ready_In = 4'b1111;
        sif.Enable_In = 1'b0;
        sif.Data_In   = 8'h99;
        sif.Valid_In  = 1'b1;
        #1;
        check("en_rdy", 32'(sif.Ready_Out), 32'd0);
        tick();
        tick();
        check("en_busy", 32'(sif.Busy_Out), 32'd0);
        check("en_data", 32'(sif.Data_Out), 32'hA5);
        sif.Valid_In = 1'b0;

        // Ptr=3: enable drops after acceptance, word still lands
        sif.Enable_In = 1'b1;
        sif.Data_In   = 8'h3C;
        sif.Valid_In  = 1'b1;
        tick();
        sif.Valid_In  = 1'b0;
        sif.Enable_In = 1'b0;
        tick();
        check("endel_cv", 32'(sif.Channel_Valid_Out), 32'h8);
        tick();
        check("endel_done", 32'(sif.Channel_Valid_Out), 32'd0);
        check("endel_busy", 32'(sif.Busy_Out), 32'd0);
        check("endel_rdy", 32'(sif.Ready_Out), 32'd0);
        sif.Enable_In = 1'b1;

        // Move Ptr to 2, then reset mid-delivery on channel 3
        sif.Channel_Ready_In = 4'b0010;
        send(8'h41, 1);
        sif.Channel_Ready_In = 4'b1000;
        sif.Data_In  = 8'h42;
        sif.Valid_In = 1'b1;
        tick();
        sif.Valid_In = 1'b0;
        tick();
        check("rd_cv", 32'(sif.Channel_Valid_Out), 32'h8);
        sif.Channel_Ready_In = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check("ar_cv", 32'(sif.Channel_Valid_Out), 32'd0);
        check("ar_busy", 32'(sif.Busy_Out), 32'd0);
        check("ar_data", 32'(sif.Data_Out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sif.Channel_Ready_In = 4'b1111;
        tick();
        send(8'h55, 0);

`ifdef DEMUX_SCHED_TIMEOUT_EN
        begin
            int n;
            bit seen;
            sif.Channel_Ready_In = 4'b0000;
            sif.Data_In  = 8'h66;
            sif.Valid_In = 1'b1;
            tick();
            sif.Valid_In = 1'b0;
            seen = 1'b0;
            n = 0;
            while (!seen && n < 40) begin
                tick();
                n++;
                seen = sif.Drop_Out;
            end
            check("to_seen", 32'(seen), 32'd1);
            check("to_cycles", 32'(n), 32'd16);
            check("to_rdy", 32'(sif.Ready_Out), 32'd1);
            tick();
            check("to_pulse", 32'(sif.Drop_Out), 32'd0);
            sif.Channel_Ready_In = 4'b1111;
            send(8'h67, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
